// File: rtl/mbscore_alu_issue_if.sv
// Bundle of the instruction, register-file, ALU and writeback signals around the
// ALU issue block. slave is the issue block's view, master the surrounding core's.
interface mbscore_alu_issue_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALU_OP_WIDTH = 4
) ();
    logic                    instr_valid;
    logic [31:0]             instr;
    logic                    instr_ready;
    logic [4:0]              rs_addr;
    logic [4:0]              rt_addr;
    logic [DATA_WIDTH-1:0]   rs_data;
    logic [DATA_WIDTH-1:0]   rt_data;
    logic                    alu_start;
    logic [DATA_WIDTH-1:0]   alu_in_a;
    logic [DATA_WIDTH-1:0]   alu_in_b;
    logic [ALU_OP_WIDTH-1:0] alu_op_type;
    logic [DATA_WIDTH-1:0]   alu_out;
    logic                    wb_valid;
    logic [4:0]              wb_addr;
    logic [DATA_WIDTH-1:0]   wb_data;
    logic                    wb_ready;
    logic                    illegal_instr;

    modport slave (
        input  instr_valid, instr, rs_data, rt_data, alu_out, wb_ready,
        output instr_ready, rs_addr, rt_addr, alu_start, alu_in_a, alu_in_b,
               alu_op_type, wb_valid, wb_addr, wb_data, illegal_instr
    );

    modport master (
        output instr_valid, instr, rs_data, rt_data, alu_out, wb_ready,
        input  instr_ready, rs_addr, rt_addr, alu_start, alu_in_a, alu_in_b,
               alu_op_type, wb_valid, wb_addr, wb_data, illegal_instr
    );
endinterface

// File: rtl/mbscore_alu_issue.sv
// Four-state MIPS ALU issue sequencer: accept, decode and read operands, issue to
// the ALU for one cycle, then hold the result on the writeback port until taken.
module mbscore_alu_issue #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALU_OP_WIDTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    mbscore_alu_issue_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_ADDU = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUBU = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] OP_NOR  = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLL  = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRL  = ALU_OP_WIDTH'(9);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRA  = ALU_OP_WIDTH'(10);
    localparam logic [ALU_OP_WIDTH-1:0] OP_LT   = ALU_OP_WIDTH'(13);
    localparam logic [ALU_OP_WIDTH-1:0] OP_LTU  = ALU_OP_WIDTH'(14);

    logic [1:0]              state_q,   state_d;
    logic [31:0]             instr_q,   instr_d;
    logic [4:0]              rs_addr_q, rs_addr_d;
    logic [4:0]              rt_addr_q, rt_addr_d;
    logic [4:0]              dest_q,    dest_d;
    logic [DATA_WIDTH-1:0]   alu_a_q,   alu_a_d;
    logic [DATA_WIDTH-1:0]   alu_b_q,   alu_b_d;
    logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
    logic [ALU_OP_WIDTH-1:0] alu_op_q,  alu_op_d;
    logic                    illegal_q, illegal_d;

    // One decoder serves both the legality check at accept and the operand latch in DECODE.
    logic [31:0]             dec_word;
    logic [5:0]              opcode, funct;
    logic [15:0]             imm;
    logic                    dec_legal;
    logic [ALU_OP_WIDTH-1:0] dec_op;
    logic [DATA_WIDTH-1:0]   dec_a, dec_b;
    logic [4:0]              dec_dest;

    assign dec_word = (state_q == S_IDLE) ? bus.instr : instr_q;
    assign opcode   = dec_word[31:26];
    assign funct    = dec_word[5:0];
    assign imm      = dec_word[15:0];

    // NOTE: every output of a combinational block gets a default first, otherwise
    // a path that skips an assignment infers a latch.
    always_comb begin
        dec_legal = 1'b1;
        dec_op    = OP_ADD;
        dec_a     = bus.rs_data;
        dec_b     = bus.rt_data;
        dec_dest  = dec_word[20:16];
        case (opcode)
            6'h00: begin
                dec_dest = dec_word[15:11];
                case (funct)
                    6'h20: dec_op = OP_ADD;
                    6'h21: dec_op = OP_ADDU;
                    6'h22: dec_op = OP_SUB;
                    6'h23: dec_op = OP_SUBU;
                    6'h24: dec_op = OP_AND;
                    6'h25: dec_op = OP_OR;
                    6'h26: dec_op = OP_XOR;
                    6'h27: dec_op = OP_NOR;
                    6'h2A: dec_op = OP_LT;
                    6'h2B: dec_op = OP_LTU;
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                        dec_a  = bus.rt_data;
                        dec_b  = funct[2] ? DATA_WIDTH'(bus.rs_data[4:0])
                                          : DATA_WIDTH'(dec_word[10:6]);
                        dec_op = (funct[1:0] == 2'b00) ? OP_SLL :
                                 (funct[1:0] == 2'b10) ? OP_SRL : OP_SRA;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08: begin dec_op = OP_ADD;  dec_b = {{(DATA_WIDTH-16){imm[15]}}, imm}; end
            6'h09: begin dec_op = OP_ADDU; dec_b = {{(DATA_WIDTH-16){imm[15]}}, imm}; end
            6'h0A: begin dec_op = OP_LT;   dec_b = {{(DATA_WIDTH-16){imm[15]}}, imm}; end
            6'h0B: begin dec_op = OP_LTU;  dec_b = {{(DATA_WIDTH-16){imm[15]}}, imm}; end
            6'h0C: begin dec_op = OP_AND;  dec_b = DATA_WIDTH'(imm); end
            6'h0D: begin dec_op = OP_OR;   dec_b = DATA_WIDTH'(imm); end
            6'h0E: begin dec_op = OP_XOR;  dec_b = DATA_WIDTH'(imm); end
            6'h0F: begin
                dec_op = OP_OR;
                dec_a  = DATA_WIDTH'({imm, 16'h0000});
                dec_b  = '0;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        rs_addr_d = rs_addr_q;
        rt_addr_d = rt_addr_q;
        dest_d    = dest_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        wb_data_d = wb_data_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    if (dec_legal) begin
                        rs_addr_d = dec_word[25:21];
                        rt_addr_d = dec_word[20:16];
                        state_d   = S_DECODE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                alu_a_d  = dec_a;
                alu_b_d  = dec_b;
                alu_op_d = dec_op;
                dest_d   = dec_dest;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                wb_data_d = bus.alu_out;
                state_d   = (dest_q == 5'd0) ? S_IDLE : S_WB;
            end
            default: begin
                if (bus.wb_ready) state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            dest_q    <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            wb_data_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            dest_q    <= dest_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            wb_data_q <= wb_data_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.instr_ready   = (state_q == S_IDLE);
    assign bus.alu_start     = (state_q == S_EXEC);
    assign bus.wb_valid      = (state_q == S_WB);
    assign bus.rs_addr       = rs_addr_q;
    assign bus.rt_addr       = rt_addr_q;
    assign bus.alu_in_a      = alu_a_q;
    assign bus.alu_in_b      = alu_b_q;
    assign bus.alu_op_type   = alu_op_q;
    assign bus.wb_addr       = dest_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.illegal_instr = illegal_q;
endmodule

// File: tb/tb_mbscore_alu_issue.sv
// Directed bench for mbscore_alu_issue: stimulus at the falling edge, outputs sampled
// at the falling edge, expected values hand-computed per instruction word.
module tb_mbscore_alu_issue;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    mbscore_alu_issue_if bus ();

    mbscore_alu_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU standing in for the real execution unit.
    always_comb begin
        case (bus.alu_op_type)
            4'd0, 4'd1: bus.alu_out = bus.alu_in_a + bus.alu_in_b;
            4'd2, 4'd3: bus.alu_out = bus.alu_in_a - bus.alu_in_b;
            4'd4:       bus.alu_out = bus.alu_in_a & bus.alu_in_b;
            4'd5:       bus.alu_out = bus.alu_in_a | bus.alu_in_b;
            4'd6:       bus.alu_out = bus.alu_in_a ^ bus.alu_in_b;
            4'd7:       bus.alu_out = ~(bus.alu_in_a | bus.alu_in_b);
            4'd8:       bus.alu_out = bus.alu_in_a << bus.alu_in_b[4:0];
            4'd9:       bus.alu_out = bus.alu_in_a >> bus.alu_in_b[4:0];
            4'd10:      bus.alu_out = $unsigned($signed(bus.alu_in_a) >>> bus.alu_in_b[4:0]);
            default:    bus.alu_out = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic run_instr(input string tag, input logic [31:0] w,
                             input logic [31:0] rsd, input logic [31:0] rtd,
                             input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] wa,
                             input logic [31:0] wd);
        bus.rs_data     = rsd;
        bus.rt_data     = rtd;
        bus.wb_ready    = 1'b1;
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check({tag, ".dec_ready"}, 32'(bus.instr_ready), 32'd0);
        check({tag, ".rs_addr"}, 32'(bus.rs_addr), 32'(w[25:21]));
        check({tag, ".rt_addr"}, 32'(bus.rt_addr), 32'(w[20:16]));
        @(negedge clk);
        check({tag, ".start"}, 32'(bus.alu_start), 32'd1);
        check({tag, ".op"}, 32'(bus.alu_op_type), 32'(op));
        check({tag, ".a"}, bus.alu_in_a, a);
        check({tag, ".b"}, bus.alu_in_b, b);
        @(negedge clk);
        check({tag, ".start_off"}, 32'(bus.alu_start), 32'd0);
        check({tag, ".a_hold"}, bus.alu_in_a, a);
        if (wa != 5'd0) begin
            check({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'd1);
            check({tag, ".wb_addr"}, 32'(bus.wb_addr), 32'(wa));
            check({tag, ".wb_data"}, bus.wb_data, wd);
            @(negedge clk);
            check({tag, ".wb_done"}, 32'(bus.wb_valid), 32'd0);
            check({tag, ".idle_ready"}, 32'(bus.instr_ready), 32'd1);
        end else begin
            check({tag, ".no_wb"}, 32'(bus.wb_valid), 32'd0);
            check({tag, ".idle_ready"}, 32'(bus.instr_ready), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] illegal_words [2];
        illegal_words[0] = 32'hFC00_0000;
        illegal_words[1] = 32'h0022_1801;

        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'h0;
        bus.rs_data     = 32'h0;
        bus.rt_data     = 32'h0;
        bus.wb_ready    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(bus.instr_ready), 32'd1);
        check("rst.start", 32'(bus.alu_start), 32'd0);
        check("rst.wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst.illegal", 32'(bus.illegal_instr), 32'd0);
        check("rst.a", bus.alu_in_a, 32'h0);
        check("rst.wb_data", bus.wb_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_instr("addu", 32'h0022_1821, 32'd5, 32'd7, 4'd1, 32'd5, 32'd7, 5'd3, 32'd12);
        run_instr("sra", 32'h0002_2103, 32'h0, 32'hF000_0000, 4'd10,
                  32'hF000_0000, 32'd4, 5'd4, 32'hFF00_0000);
        run_instr("sllv", 32'h0082_2004, 32'h0000_0023, 32'd1, 4'd8,
                  32'd1, 32'd3, 5'd4, 32'd8);
        run_instr("ori", 32'h3422_8001, 32'h0000_0F00, 32'h0, 4'd5,
                  32'h0000_0F00, 32'h0000_8001, 5'd2, 32'h0000_8F01);
        run_instr("addu_rd0", 32'h0022_0021, 32'd5, 32'd7, 4'd1, 32'd5, 32'd7, 5'd0, 32'd0);

        // lui with writeback stalled for three cycles
        bus.wb_ready    = 1'b0;
        bus.instr       = 32'h3C05_1234;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("lui.op", 32'(bus.alu_op_type), 32'd5);
        check("lui.a", bus.alu_in_a, 32'h1234_0000);
        check("lui.b", bus.alu_in_b, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lui.wb_valid", 32'(bus.wb_valid), 32'd1);
            check("lui.wb_addr", 32'(bus.wb_addr), 32'd5);
            check("lui.wb_data", bus.wb_data, 32'h1234_0000);
            check("lui.ready", 32'(bus.instr_ready), 32'd0);
        end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        check("lui.wb_done", 32'(bus.wb_valid), 32'd0);

        // Unsupported words: single illegal pulse, no issue
        for (int k = 0; k < 2; k++) begin
            bus.instr       = illegal_words[k];
            bus.instr_valid = 1'b1;
            @(negedge clk);
            bus.instr_valid = 1'b0;
            check("ill.pulse", 32'(bus.illegal_instr), 32'd1);
            check("ill.ready", 32'(bus.instr_ready), 32'd1);
            check("ill.start", 32'(bus.alu_start), 32'd0);
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                check("ill.pulse_end", 32'(bus.illegal_instr), 32'd0);
                check("ill.no_start", 32'(bus.alu_start), 32'd0);
                check("ill.idle", 32'(bus.instr_ready), 32'd1);
            end
        end

        // Reset asserted while the ALU strobe is high
        bus.rs_data     = 32'd5;
        bus.rt_data     = 32'd7;
        bus.instr       = 32'h0022_1821;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("rexec.start", 32'(bus.alu_start), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rexec.start_off", 32'(bus.alu_start), 32'd0);
        check("rexec.ready", 32'(bus.instr_ready), 32'd1);
        check("rexec.a", bus.alu_in_a, 32'h0);
        check("rexec.b", bus.alu_in_b, 32'h0);
        check("rexec.op", 32'(bus.alu_op_type), 32'd0);
        check("rexec.rs_addr", 32'(bus.rs_addr), 32'd0);
        check("rexec.wb_addr", 32'(bus.wb_addr), 32'd0);
        @(negedge clk);
        check("rexec.no_wb", 32'(bus.wb_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_instr("addi", 32'h2022_FFFF, 32'd5, 32'h0, 4'd0,
                  32'd5, 32'hFFFF_FFFF, 5'd2, 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
